// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard controller for a five-stage in-order core. It decides
//   every cycle whether the front end must hold (stall), whether IF_ID or
//   ID_EXE must receive a bubble (empty), and, optionally, which pipeline
//   stage feeds each ALU operand. A three-state register (RUN, STALL, FLUSH)
//   is the only control state. Two saturating performance counters track
//   stall and flush cycles.
//
//   Build option:
//     HAZARD_FWD_EN  defined   -> operand forwarding enabled; only a load
//                                 followed by a dependent instruction stalls
//                                 (one cycle, via the STALL state).
//                    undefined -> no forwarding; any RAW dependency on an
//                                 instruction in EXE or MEM stalls in RUN
//                                 until the producer reaches WB.
//
//   Ports
//     Clk, reset                    clock, synchronous active-high reset
//     id_num_1/id_num_2/id_use_rt   rs/rt of the ID instruction, rt used
//     ex_memRead/ex_regWrite/ex_dest/ex_num_1/ex_num_2   from ID_EXE
//     mem_regWrite/mem_dest         from EXE_MEM
//     wb_regWrite/wb_dest           from MEM_WB
//     branch_taken_ex               taken branch/jr/jump resolved in EXE
//     jump_id                       j/jal decoded in ID
//     mem_busy                      data memory wait request
//     PC_STALL..EXE_MEM_STALL       hold PC / stage registers
//     IF_ID_EMPTY, EMPTY            bubble into IF_ID / ID_EXE
//     fwd_a, fwd_b                  00 regfile, 10 EXE_MEM, 01 MEM_WB
//     stall_cnt, flush_cnt          saturating performance counters
// -----------------------------------------------------------------------------
module hazard_unit (
  input  logic        Clk,
  input  logic        reset,
  input  logic [4:0]  id_num_1,
  input  logic [4:0]  id_num_2,
  input  logic        id_use_rt,
  input  logic        ex_memRead,
  input  logic        ex_regWrite,
  input  logic [4:0]  ex_dest,
  input  logic [4:0]  ex_num_1,
  input  logic [4:0]  ex_num_2,
  input  logic        mem_regWrite,
  input  logic [4:0]  mem_dest,
  input  logic        wb_regWrite,
  input  logic [4:0]  wb_dest,
  input  logic        branch_taken_ex,
  input  logic        jump_id,
  input  logic        mem_busy,
  output logic        PC_STALL,
  output logic        IF_ID_STALL,
  output logic        ID_EXE_STALL,
  output logic        EXE_MEM_STALL,
  output logic        IF_ID_EMPTY,
  output logic        EMPTY,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic        ex_hit;
  logic        dep_stall;
  logic [1:0]  fwd_a_raw, fwd_b_raw;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    logic [15:0] r;
    r = v;
    if (en && (v != 16'hFFFF)) r = v + 16'd1;
    return r;
  endfunction

  // A destination register hits the ID instruction only when it is not r0.
  function automatic logic id_reads(input logic [4:0] dest, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic use_rt);
    return (dest != 5'd0) && ((dest == rs) || (use_rt && (dest == rt)));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic m_we, input logic [4:0] m_dst,
                                         input logic w_we, input logic [4:0] w_dst);
    logic [1:0] r;
    r = 2'b00;
    if (src != 5'd0) begin
      // EXE_MEM holds the younger value, so it wins over MEM_WB.
      if (m_we && (m_dst == src))      r = 2'b10;
      else if (w_we && (w_dst == src)) r = 2'b01;
    end
    return r;
  endfunction

  assign ex_hit = id_reads(ex_dest, id_num_1, id_num_2, id_use_rt);

`ifdef HAZARD_FWD_EN
  // With forwarding only a load result is too late for the next instruction;
  // one bubble is enough, tracked by the STALL state.
  localparam logic DEP_ENTERS_STALL = 1'b1;
  logic unused_inputs;
  assign unused_inputs = ex_regWrite;
  assign dep_stall = ex_memRead && ex_hit;
  assign fwd_a_raw = fwd_sel(ex_num_1, mem_regWrite, mem_dest, wb_regWrite, wb_dest);
  assign fwd_b_raw = fwd_sel(ex_num_2, mem_regWrite, mem_dest, wb_regWrite, wb_dest);
`else
  // Without forwarding the consumer waits in RUN, re-checking each cycle,
  // until the producer has left both EXE and MEM. A load writes its
  // destination too, so it is covered whether or not ex_regWrite is set.
  localparam logic DEP_ENTERS_STALL = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{ex_num_1, ex_num_2, wb_regWrite, wb_dest};
  assign dep_stall = ((ex_regWrite || ex_memRead) && ex_hit) ||
                     (mem_regWrite && id_reads(mem_dest, id_num_1, id_num_2, id_use_rt));
  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;
`endif

  // Decision: combinational from inputs and state, applied at the next edge
  always_comb begin
    PC_STALL      = 1'b0;
    IF_ID_STALL   = 1'b0;
    ID_EXE_STALL  = 1'b0;
    EXE_MEM_STALL = 1'b0;
    IF_ID_EMPTY   = 1'b0;
    EMPTY         = 1'b0;
    fwd_a         = 2'b00;
    fwd_b         = 2'b00;
    state_d       = state_q;
    if (reset) begin
      state_d = S_RUN;
    end else begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (mem_busy) begin
        // Freeze the whole pipe; state holds so a pending branch is
        // re-evaluated once memory is ready.
        PC_STALL      = 1'b1;
        IF_ID_STALL   = 1'b1;
        ID_EXE_STALL  = 1'b1;
        EXE_MEM_STALL = 1'b1;
      end else if (branch_taken_ex) begin
        IF_ID_EMPTY = 1'b1;
        EMPTY       = 1'b1;
        state_d     = S_FLUSH;
      end else begin
        state_d = S_RUN;
        case (state_q)
          S_RUN: begin
            if (dep_stall) begin
              PC_STALL    = 1'b1;
              IF_ID_STALL = 1'b1;
              EMPTY       = 1'b1;
              state_d     = DEP_ENTERS_STALL ? S_STALL : S_RUN;
            end else if (jump_id) begin
              IF_ID_EMPTY = 1'b1;
            end
          end
          // The load has moved on; the held instruction must not re-trigger.
          S_STALL: IF_ID_EMPTY = jump_id;
          // IF_ID already carries a bubble; nothing in ID is real.
          default: ;
        endcase
      end
    end
  end

  assign stall_cnt_d = sat_inc(stall_cnt_q, PC_STALL);
  assign flush_cnt_d = sat_inc(flush_cnt_q, IF_ID_EMPTY);

  // State and counter registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  logic        Clk = 1'b0;
  logic        reset;
  logic [4:0]  id_num_1, id_num_2;
  logic        id_use_rt;
  logic        ex_memRead, ex_regWrite;
  logic [4:0]  ex_dest, ex_num_1, ex_num_2;
  logic        mem_regWrite;
  logic [4:0]  mem_dest;
  logic        wb_regWrite;
  logic [4:0]  wb_dest;
  logic        branch_taken_ex, jump_id, mem_busy;
  logic        PC_STALL, IF_ID_STALL, ID_EXE_STALL, EXE_MEM_STALL;
  logic        IF_ID_EMPTY, EMPTY;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int errors  = 0;

  hazard_unit dut (
    .Clk(Clk), .reset(reset),
    .id_num_1(id_num_1), .id_num_2(id_num_2), .id_use_rt(id_use_rt),
    .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite), .ex_dest(ex_dest),
    .ex_num_1(ex_num_1), .ex_num_2(ex_num_2),
    .mem_regWrite(mem_regWrite), .mem_dest(mem_dest),
    .wb_regWrite(wb_regWrite), .wb_dest(wb_dest),
    .branch_taken_ex(branch_taken_ex), .jump_id(jump_id), .mem_busy(mem_busy),
    .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .ID_EXE_STALL(ID_EXE_STALL),
    .EXE_MEM_STALL(EXE_MEM_STALL), .IF_ID_EMPTY(IF_ID_EMPTY), .EMPTY(EMPTY),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 Clk = ~Clk;

  // {PC, IF_ID, ID_EXE, EXE_MEM stalls, IF_ID_EMPTY, EMPTY}
  logic [5:0] ctl;
  assign ctl = {PC_STALL, IF_ID_STALL, ID_EXE_STALL, EXE_MEM_STALL, IF_ID_EMPTY, EMPTY};

  // ---------------- reference model ----------------
  // Phase of the pipe as seen by the controller: normal running, the cycle
  // after a load bubble was inserted, or the cycle after a taken branch.
  localparam int P_RUN = 0, P_AFTER_LOAD = 1, P_AFTER_BRANCH = 2;
  int m_phase = P_RUN, m_next = P_RUN;
  int m_scnt = 0, m_fcnt = 0;
  logic [5:0] e_ctl;
  logic [1:0] e_fa, e_fb;

  function automatic bit id_reads(input logic [4:0] r);
    return (r != 0) && (r == id_num_1 || (id_use_rt && r == id_num_2));
  endfunction

  function automatic logic [1:0] pick_src(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (mem_regWrite && mem_dest == src) return 2'b10;
    if (wb_regWrite && wb_dest == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit dep, to_bubble_phase;
    e_ctl = 6'b0; e_fa = 2'b00; e_fb = 2'b00; m_next = m_phase;
    if (reset) begin
      m_next = P_RUN;
      return;
    end
`ifdef HAZARD_FWD_EN
    e_fa = pick_src(ex_num_1);
    e_fb = pick_src(ex_num_2);
    dep = ex_memRead && id_reads(ex_dest);
    to_bubble_phase = 1;
`else
    dep = ((ex_regWrite || ex_memRead) && id_reads(ex_dest)) ||
          (mem_regWrite && id_reads(mem_dest));
    to_bubble_phase = 0;
`endif
    if (mem_busy) e_ctl = 6'b111100;
    else if (branch_taken_ex) begin
      e_ctl = 6'b000011; m_next = P_AFTER_BRANCH;
    end else begin
      m_next = P_RUN;
      if (m_phase == P_RUN && dep) begin
        e_ctl = 6'b110001;
        if (to_bubble_phase) m_next = P_AFTER_LOAD;
      end else if (m_phase != P_AFTER_BRANCH && jump_id) e_ctl = 6'b000010;
    end
  endtask

  // Advance one clock; the model follows whatever inputs are applied.
  task automatic tick();
    model_eval();
    if (reset) begin
      m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e_ctl[5]) m_scnt = (m_scnt >= 65535) ? 65535 : m_scnt + 1;
      if (e_ctl[1]) m_fcnt = (m_fcnt >= 65535) ? 65535 : m_fcnt + 1;
    end
    m_phase = m_next;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle();
    id_num_1 = 0; id_num_2 = 0; id_use_rt = 0;
    ex_memRead = 0; ex_regWrite = 0; ex_dest = 0; ex_num_1 = 0; ex_num_2 = 0;
    mem_regWrite = 0; mem_dest = 0; wb_regWrite = 0; wb_dest = 0;
    branch_taken_ex = 0; jump_id = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    set_idle();
    mem_busy = 1; branch_taken_ex = 1; jump_id = 1;
    ex_memRead = 1; ex_regWrite = 1; ex_dest = 5; id_num_1 = 5;
    mem_regWrite = 1; mem_dest = 3; ex_num_1 = 3;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++;
      if ({ctl, fwd_a, fwd_b} !== 10'b0) begin
        errors++; $display("FAIL reset_outputs: got %b want 0000000000", {ctl, fwd_a, fwd_b});
      end
      tick();
    end
    vectors++;
    if ({stall_cnt, flush_cnt} !== 32'h0) begin
      errors++; $display("FAIL reset_counters: got %h/%h want 0000/0000", stall_cnt, flush_cnt);
    end
    reset = 0;
    set_idle();
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memRead = 1; ex_dest = 5; id_num_1 = 5;
    #2;
    vectors++;
    if (ctl !== 6'b110001) begin
      errors++; $display("FAIL load_use_first: got %b want 110001", ctl);
    end
    tick();
    #2;
`ifdef HAZARD_FWD_EN
    vectors++;
    if (ctl !== 6'b000000) begin
      errors++; $display("FAIL load_use_stall_state: got %b want 000000", ctl);
    end
    vectors++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
    end
    tick();
    #2;
    vectors++;
    if (ctl !== 6'b110001) begin
      errors++; $display("FAIL load_use_back_to_run: got %b want 110001", ctl);
    end
`else
    vectors++;
    if (ctl !== 6'b110001) begin
      errors++; $display("FAIL load_use_repeat: got %b want 110001", ctl);
    end
    vectors++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
    end
`endif
    set_idle();
    tick();
  endtask

  task automatic test_forwarding();
    logic [3:0] want [4];
`ifdef HAZARD_FWD_EN
    want[0] = 4'b1000; want[1] = 4'b1010; want[2] = 4'b0101; want[3] = 4'b0000;
`else
    want[0] = 4'b0000; want[1] = 4'b0000; want[2] = 4'b0000; want[3] = 4'b0000;
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_idle();
      case (k)
        0: begin mem_regWrite = 1; mem_dest = 3; wb_regWrite = 1; wb_dest = 3;
                 ex_num_1 = 3; ex_num_2 = 0; end
        1: begin mem_regWrite = 1; mem_dest = 3; wb_regWrite = 1; wb_dest = 3;
                 ex_num_1 = 3; ex_num_2 = 3; end
        2: begin mem_regWrite = 0; mem_dest = 3; wb_regWrite = 1; wb_dest = 3;
                 ex_num_1 = 3; ex_num_2 = 3; end
        default: begin mem_regWrite = 1; mem_dest = 0; wb_regWrite = 1; wb_dest = 0;
                 ex_num_1 = 0; ex_num_2 = 0; end
      endcase
      #2;
      vectors++;
      if ({fwd_a, fwd_b} !== want[k]) begin
        errors++; $display("FAIL fwd_case%0d: got %b want %b", k, {fwd_a, fwd_b}, want[k]);
      end
      tick();
    end
    set_idle();
    tick();
  endtask

  task automatic test_branch_priority();
    logic [15:0] f0;
    do_reset();
    ex_memRead = 1; ex_regWrite = 1; ex_dest = 5; id_num_1 = 5;
    branch_taken_ex = 1; jump_id = 1;
    #2;
    vectors++;
    if (ctl !== 6'b000011) begin
      errors++; $display("FAIL branch_over_load: got %b want 000011", ctl);
    end
    f0 = flush_cnt;
    tick();
    vectors++;
    if (flush_cnt !== f0 + 16'd1) begin
      errors++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt, f0 + 16'd1);
    end
    branch_taken_ex = 0;
    #2;
    vectors++;
    if (ctl !== 6'b000000) begin
      errors++; $display("FAIL flush_state_masks: got %b want 000000", ctl);
    end
    tick();
    jump_id = 0;
    #2;
    vectors++;
    if (ctl !== 6'b110001) begin
      errors++; $display("FAIL after_flush_run: got %b want 110001", ctl);
    end
    set_idle();
    jump_id = 1;
    #2;
    vectors++;
    if (ctl !== 6'b000010) begin
      errors++; $display("FAIL jump_bubble: got %b want 000010", ctl);
    end
    set_idle();
    tick();
  endtask

  task automatic test_membusy_branch();
    logic [15:0] s0, f0;
    do_reset();
    s0 = stall_cnt; f0 = flush_cnt;
    mem_busy = 1; branch_taken_ex = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++;
      if (ctl !== 6'b111100) begin
        errors++; $display("FAIL busy_cycle%0d: got %b want 111100", i, ctl);
      end
      tick();
    end
    mem_busy = 0;
    #2;
    vectors++;
    if (ctl !== 6'b000011) begin
      errors++; $display("FAIL busy_release_flush: got %b want 000011", ctl);
    end
    vectors++;
    if ({stall_cnt, flush_cnt} !== {s0 + 16'd3, f0}) begin
      errors++; $display("FAIL busy_counters: got %0d/%0d want %0d/%0d",
                         stall_cnt, flush_cnt, s0 + 16'd3, f0);
    end
    tick();
    vectors++;
    if (flush_cnt !== f0 + 16'd1) begin
      errors++; $display("FAIL busy_flush_cnt: got %0d want %0d", flush_cnt, f0 + 16'd1);
    end
    set_idle();
    tick();
  endtask

  task automatic test_raw_chain();
    logic [5:0] want_dep;
`ifdef HAZARD_FWD_EN
    want_dep = 6'b000000;
`else
    want_dep = 6'b110001;
`endif
    do_reset();
    ex_regWrite = 1; ex_dest = 7; id_num_1 = 1; id_num_2 = 7; id_use_rt = 1;
    #2;
    vectors++;
    if (ctl !== want_dep) begin
      errors++; $display("FAIL raw_in_ex: got %b want %b", ctl, want_dep);
    end
    tick();
    ex_regWrite = 0; ex_dest = 0; mem_regWrite = 1; mem_dest = 7;
    #2;
    vectors++;
    if (ctl !== want_dep) begin
      errors++; $display("FAIL raw_in_mem: got %b want %b", ctl, want_dep);
    end
    tick();
    mem_regWrite = 0; mem_dest = 0; wb_regWrite = 1; wb_dest = 7;
    #2;
    vectors++;
    if (ctl !== 6'b000000) begin
      errors++; $display("FAIL raw_released: got %b want 000000", ctl);
    end
    vectors++;
    if (stall_cnt !== {14'd0, want_dep[5], 1'b0}) begin
      errors++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, want_dep[5] ? 2 : 0);
    end
    tick();
    set_idle();
    ex_memRead = 1; ex_regWrite = 1; ex_dest = 0; id_num_1 = 0;
    #2;
    vectors++;
    if (ctl !== 6'b000000) begin
      errors++; $display("FAIL r0_ignored: got %b want 000000", ctl);
    end
    tick();
    set_idle();
    ex_memRead = 1; ex_regWrite = 1; ex_dest = 4; id_num_1 = 9; id_num_2 = 4; id_use_rt = 0;
    #2;
    vectors++;
    if (ctl !== 6'b000000) begin
      errors++; $display("FAIL rt_unused: got %b want 000000", ctl);
    end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 39) == 0);
      id_num_1        = 5'($urandom_range(0, 3));
      id_num_2        = 5'($urandom_range(0, 3));
      id_use_rt       = 1'($urandom);
      ex_memRead      = 1'($urandom);
      ex_regWrite     = 1'($urandom);
      ex_dest         = 5'($urandom_range(0, 3));
      ex_num_1        = 5'($urandom_range(0, 3));
      ex_num_2        = 5'($urandom_range(0, 3));
      mem_regWrite    = 1'($urandom);
      mem_dest        = 5'($urandom_range(0, 3));
      wb_regWrite     = 1'($urandom);
      wb_dest         = 5'($urandom_range(0, 3));
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      jump_id         = ($urandom_range(0, 3) == 0);
      mem_busy        = ($urandom_range(0, 7) == 0);
      #2;
      model_eval();
      vectors++;
      if ({ctl, fwd_a, fwd_b} !== {e_ctl, e_fa, e_fb}) begin
        errors++; $display("FAIL random_outputs@%0d: got %b want %b", i,
                           {ctl, fwd_a, fwd_b}, {e_ctl, e_fa, e_fb});
      end
      vectors++;
      if ({stall_cnt, flush_cnt} !== {16'(m_scnt), 16'(m_fcnt)}) begin
        errors++; $display("FAIL random_counters@%0d: got %0d/%0d want %0d/%0d", i,
                           stall_cnt, flush_cnt, m_scnt, m_fcnt);
      end
      tick();
    end
    reset = 0;
    set_idle();
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    mem_busy = 1;
    repeat (65534) tick();
    #2;
    vectors++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_preload: got %h want fffe", stall_cnt);
    end
    tick();
    tick();
    mem_busy = 0;
    ex_memRead = 1; ex_regWrite = 1; ex_dest = 5; id_num_1 = 5;
    #2;
    vectors++;
    if (ctl !== 6'b110001) begin
      errors++; $display("FAIL sat_third_stall: got %b want 110001", ctl);
    end
    tick();
    vectors++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: got %h want ffff", stall_cnt);
    end
    reset = 1; jump_id = 1;
    #2;
    vectors++;
    if ({ctl, fwd_a, fwd_b} !== 10'b0) begin
      errors++; $display("FAIL reset_in_stall: got %b want 0000000000", {ctl, fwd_a, fwd_b});
    end
    tick();
    reset = 0;
    set_idle();
    #2;
    vectors++;
    if ({stall_cnt, flush_cnt, ctl} !== 38'b0) begin
      errors++; $display("FAIL post_reset_clear: got %h/%h/%b want 0000/0000/000000",
                         stall_cnt, flush_cnt, ctl);
    end
    ex_memRead = 1; ex_regWrite = 1; ex_dest = 5; id_num_1 = 5;
    #2;
    vectors++;
    if (ctl !== 6'b110001) begin
      errors++; $display("FAIL post_reset_run: got %b want 110001", ctl);
    end
    set_idle();
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1;
    set_idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_priority();
    test_membusy_branch();
    test_raw_chain();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high, and the ports SHALL be named Clk and reset.
REQ-002 Clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_num_1, id_num_2  in  5 each  rs and rt of the instruction in IF_ID; id_use_rt  in  1  the instruction reads rt.
REQ-005 ex_memRead, ex_regWrite  in  1 each; ex_dest  in  5; ex_num_1, ex_num_2  in  5 each; all four come from the ID_EXE outputs.
REQ-006 mem_regWrite  in  1; mem_dest  in  5; both come from EXE_MEM.
REQ-007 wb_regWrite  in  1; wb_dest  in  5; both come from MEM_WB.
REQ-008 branch_taken_ex  in  1  a branch, jr or jump resolved taken in EXE.
REQ-009 jump_id  in  1  a j or jal decoded in ID.
REQ-010 mem_busy  in  1  data memory wait request.
REQ-011 PC_STALL, IF_ID_STALL, ID_EXE_STALL, EXE_MEM_STALL  out  1 each  hold the PC or the named stage register.
REQ-012 IF_ID_EMPTY, EMPTY  out  1 each  one-cycle bubble requests for IF_ID and ID_EXE.
REQ-013 fwd_a, fwd_b  out  2 each  ALU operand source selects: 00 is the register file, 10 is EXE_MEM, 01 is MEM_WB.
REQ-014 stall_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-015 The stall and flush outputs SHALL be combinational from the current inputs and the state register; the decision SHALL take effect at the next edge (zero-cycle latency).
REQ-016 The states SHALL be RUN, STALL and FLUSH, and the state register SHALL be the only control state.
REQ-017 The condition for a hazard SHALL be a destination register that is nonzero and matches; any match against r0 SHALL be ignored.
REQ-018 The events SHALL be resolved in this priority order: mem_busy, then branch_taken_ex, then load-use, then jump_id, then none.
REQ-019 When mem_busy is 1, all four stall outputs SHALL be 1 and IF_ID_EMPTY and EMPTY SHALL be 0; the state SHALL hold; a pending branch SHALL be re-evaluated once mem_busy falls.
REQ-020 When branch_taken_ex is 1 (without mem_busy), IF_ID_EMPTY SHALL be 1, EMPTY SHALL be 1 and all stall outputs SHALL be 0; the next state SHALL be FLUSH.
REQ-021 The load-use condition in RUN SHALL be: ex_memRead=1 and ex_dest equal to id_num_1, or ex_dest equal to id_num_2 when id_use_rt=1.
REQ-022 On load-use, PC_STALL and IF_ID_STALL SHALL be 1 and EMPTY SHALL be 1; the next state SHALL be STALL.
REQ-023 jump_id in RUN, with no higher-priority event, SHALL give IF_ID_EMPTY=1 for one cycle and no stall.
REQ-024 STALL SHALL last one cycle, with load-use detection masked, and SHALL then return to RUN; a branch_taken_ex in STALL SHALL be handled by REQ-020.
REQ-025 FLUSH SHALL last one cycle, with load-use and jump_id detection masked, and SHALL then return to RUN.
REQ-026 stall_cnt SHALL increment on each cycle in which PC_STALL=1, and SHALL saturate at 0xFFFF with no wrap.
REQ-027 flush_cnt SHALL increment on each cycle in which IF_ID_EMPTY=1, and SHALL saturate at 0xFFFF.

Reset
REQ-028 While reset=1 at an edge, the state SHALL go to RUN and both counters SHALL clear to 0.
REQ-029 While reset=1, all stall and empty outputs SHALL read 0 and fwd_a and fwd_b SHALL read 00, regardless of the other inputs.
REQ-030 A reset asserted during STALL or FLUSH SHALL abort that state at once, with no residual bubble.

Configuration
REQ-031 The macro HAZARD_FWD_EN, when defined, SHALL enable forwarding.
REQ-032 With HAZARD_FWD_EN, fwd_a SHALL be 10 if mem_regWrite=1 and mem_dest equals ex_num_1; otherwise 01 if wb_regWrite=1 and wb_dest equals ex_num_1; otherwise 00. fwd_b SHALL follow the same rule using ex_num_2. The EXE_MEM source SHALL win when both stages match.
REQ-033 Without HAZARD_FWD_EN, fwd_a and fwd_b SHALL be tied to 00.
REQ-034 Without HAZARD_FWD_EN, any RAW match of an ID source against ex_dest (when ex_regWrite=1) or mem_dest (when mem_regWrite=1) SHALL give PC_STALL=1, IF_ID_STALL=1 and EMPTY=1. This stall SHALL repeat every cycle until no match remains, and SHALL stay in RUN. The load-use path SHALL be subsumed by this stall.

Verification
REQ-035 The bench SHALL drive lw with ex_dest=5 and id_num_1=5, with HAZARD_FWD_EN defined. Required: one cycle with PC_STALL=1, IF_ID_STALL=1, EMPTY=1, then STALL, then RUN, and stall_cnt=1.
REQ-036 The bench SHALL drive mem_regWrite=1, mem_dest=3, wb_regWrite=1, wb_dest=3, ex_num_1=3 and ex_num_2=0. Required: fwd_a=10 and fwd_b=00.
REQ-037 The bench SHALL drive branch_taken_ex=1 together with a load-use match. Required: IF_ID_EMPTY=1, EMPTY=1, PC_STALL=0, next state FLUSH, and flush_cnt incremented by 1.
REQ-038 The bench SHALL drive mem_busy=1 for 3 cycles with branch_taken_ex=1. Required: all stalls high and no empty pulse for 3 cycles, then the flush on cycle 4.
REQ-039 Without HAZARD_FWD_EN, the bench SHALL drive add with ex_dest=7 and id_num_2=7, id_use_rt=1. Required: a 2-cycle stall while the producer moves from EXE to MEM, then release.
REQ-040 The bench SHALL preload stall_cnt to 0xFFFE and apply 3 stalls, then assert reset during STALL. Required: the counter holds at 0xFFFF, then the next cycle gives state RUN, counters 0 and all outputs 0.
